// File: rtl/cpu_consts_pkg.sv
// Shared constants for the execute-stage branch resolution logic.
// The optional BRANCH_PERF_CNT_EN build adds counters to branch_resolve.
package cpu_consts;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } redir_state_e;

    localparam int unsigned PC_INC = 4;

    // JALR clears bit 0 of the computed address.
    localparam logic [63:0] JALR_LSB_MASK = ~64'd1;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target, taken, fall-through and misalignment computation
// for B-type, JAL and JALR instructions.
module branch_target_calc
    import cpu_consts::JALR_LSB_MASK;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned PC_INC = 4
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] base_i,
    input  logic            is_jal_i,
    input  logic            is_jalr_i,
    input  logic            branch_taken_i,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] actual_next_o,
    output logic            misaligned_o
);

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] pc_rel_sum;

    always_comb begin
        jalr_sum      = base_i + imm_i;
        pc_rel_sum    = pc_i + imm_i;
        taken_o       = is_jal_i | is_jalr_i | branch_taken_i;
        target_o      = is_jalr_i ? (jalr_sum & XLEN'(JALR_LSB_MASK)) : pc_rel_sum;
        actual_next_o = taken_o ? target_o : (pc_i + XLEN'(PC_INC));
        // Only 4-byte alignment is legal: no compressed instructions.
        misaligned_o  = taken_o & (target_o[1:0] != 2'b00);
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves control instructions in execute: redirects fetch on mispredict,
// flags misaligned targets and emits predictor updates. Macro: BRANCH_PERF_CNT_EN.
module branch_resolve
    import cpu_consts::redir_state_e;
    import cpu_consts::IDLE;
    import cpu_consts::REDIR;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned PC_INC = cpu_consts::PC_INC
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            ex_valid_i,
    input  logic            is_b_type_i,
    input  logic            is_jal_i,
    input  logic            is_jalr_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_imm_i,
    input  logic [XLEN-1:0] jalr_base_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_target_i,
    input  logic            redirect_ready_i,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic            ex_stall_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o,
    output logic            upd_valid_o,
    output logic [XLEN-1:0] upd_pc_o,
    output logic            upd_taken_o,
    output logic [XLEN-1:0] upd_target_o
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [63:0]     branch_cnt_o,
    output logic [63:0]     mispredict_cnt_o
`endif
);

    // Redirect handshake: redirect_pc_o is held stable while redirect_valid_o
    // is high and the transfer completes on a cycle with valid & ready.

    redir_state_e    state_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            flush_q;
    logic            ex_stall_q;
    logic            misalign_q;
    logic [XLEN-1:0] misalign_addr_q;
    logic            upd_valid_q;
    logic [XLEN-1:0] upd_pc_q;
    logic            upd_taken_q;
    logic [XLEN-1:0] upd_target_q;
`ifdef BRANCH_PERF_CNT_EN
    logic [63:0]     branch_cnt_q;
    logic [63:0]     mispredict_cnt_q;
`endif

    logic            ctl;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] actual_next;
    logic            misaligned;
    logic            mispredict;

    branch_target_calc #(
        .XLEN   (XLEN),
        .PC_INC (PC_INC)
    ) u_calc (
        .pc_i           (ex_pc_i),
        .imm_i          (ex_imm_i),
        .base_i         (jalr_base_i),
        .is_jal_i       (is_jal_i),
        .is_jalr_i      (is_jalr_i),
        .branch_taken_i (branch_taken_i),
        .taken_o        (taken),
        .target_o       (target),
        .actual_next_o  (actual_next),
        .misaligned_o   (misaligned)
    );

    always_comb begin
        ctl        = ex_valid_i & (is_b_type_i | is_jal_i | is_jalr_i);
        mispredict = (pred_taken_i != taken) | (taken & (pred_target_i != target));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            ex_stall_q       <= 1'b0;
            misalign_q       <= 1'b0;
            misalign_addr_q  <= '0;
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_taken_q      <= 1'b0;
            upd_target_q     <= '0;
`ifdef BRANCH_PERF_CNT_EN
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
`endif
        end else begin
            flush_q     <= 1'b0;
            misalign_q  <= 1'b0;
            upd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ctl) begin
                        if (misaligned) begin
                            misalign_q      <= 1'b1;
                            misalign_addr_q <= target;
                        end else begin
                            upd_valid_q  <= 1'b1;
                            upd_pc_q     <= ex_pc_i;
                            upd_taken_q  <= taken;
                            upd_target_q <= target;
`ifdef BRANCH_PERF_CNT_EN
                            branch_cnt_q <= branch_cnt_q + 64'd1;
`endif
                            if (mispredict) begin
                                state_q          <= REDIR;
                                redirect_valid_q <= 1'b1;
                                redirect_pc_q    <= actual_next;
                                flush_q          <= 1'b1;
                                ex_stall_q       <= 1'b1;
`ifdef BRANCH_PERF_CNT_EN
                                mispredict_cnt_q <= mispredict_cnt_q + 64'd1;
`endif
                            end
                        end
                    end
                end
                REDIR: begin
                    // Execute is stalled here, so any ctl on the inputs is ignored.
                    if (redirect_ready_i) begin
                        state_q          <= IDLE;
                        redirect_valid_q <= 1'b0;
                        ex_stall_q       <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_o          = flush_q;
    assign ex_stall_o       = ex_stall_q;
    assign misalign_o       = misalign_q;
    assign misalign_addr_o  = misalign_addr_q;
    assign upd_valid_o      = upd_valid_q;
    assign upd_pc_o         = upd_pc_q;
    assign upd_taken_o      = upd_taken_q;
    assign upd_target_o     = upd_target_q;
`ifdef BRANCH_PERF_CNT_EN
    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vectors, a cycle model
// derived from the branch rules, and literal checks on key cycles.
module tb_branch_resolve;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            resetn;
    logic            ex_valid_i, is_b_type_i, is_jal_i, is_jalr_i, branch_taken_i;
    logic [XLEN-1:0] ex_pc_i, ex_imm_i, jalr_base_i, pred_target_i;
    logic            pred_taken_i, redirect_ready_i;
    logic            redirect_valid_o, flush_o, ex_stall_o, misalign_o;
    logic            upd_valid_o, upd_taken_o;
    logic [XLEN-1:0] redirect_pc_o, misalign_addr_o, upd_pc_o, upd_target_o;
`ifdef BRANCH_PERF_CNT_EN
    logic [63:0]     branch_cnt_o, mispredict_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve #(.XLEN(XLEN), .PC_INC(4)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .ex_valid_i       (ex_valid_i),
        .is_b_type_i      (is_b_type_i),
        .is_jal_i         (is_jal_i),
        .is_jalr_i        (is_jalr_i),
        .branch_taken_i   (branch_taken_i),
        .ex_pc_i          (ex_pc_i),
        .ex_imm_i         (ex_imm_i),
        .jalr_base_i      (jalr_base_i),
        .pred_taken_i     (pred_taken_i),
        .pred_target_i    (pred_target_i),
        .redirect_ready_i (redirect_ready_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .flush_o          (flush_o),
        .ex_stall_o       (ex_stall_o),
        .misalign_o       (misalign_o),
        .misalign_addr_o  (misalign_addr_o),
        .upd_valid_o      (upd_valid_o),
        .upd_pc_o         (upd_pc_o),
        .upd_taken_o      (upd_taken_o),
        .upd_target_o     (upd_target_o)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .branch_cnt_o     (branch_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: "busy" means a redirect is outstanding and fetch has not taken it.
    logic        m_busy, m_rv, m_flush, m_stall, m_mis, m_upd, m_utk;
    logic [63:0] m_rpc, m_maddr, m_upc, m_utgt;
    logic [63:0] m_bcnt, m_mcnt;

    always @(posedge clk or negedge resetn) begin
        logic [63:0] tgt, nxt;
        logic        tk;
        if (!resetn) begin
            m_busy = 0; m_rv = 0; m_flush = 0; m_stall = 0; m_mis = 0; m_upd = 0; m_utk = 0;
            m_rpc = 0; m_maddr = 0; m_upc = 0; m_utgt = 0; m_bcnt = 0; m_mcnt = 0;
        end else begin
            m_flush = 0; m_mis = 0; m_upd = 0;
            if (m_busy) begin
                if (redirect_ready_i) begin
                    m_busy = 0; m_rv = 0; m_stall = 0;
                end
            end else if (ex_valid_i && (is_b_type_i || is_jal_i || is_jalr_i)) begin
                if (is_jalr_i) begin
                    tgt = jalr_base_i + ex_imm_i;
                    tgt = tgt - (tgt % 2);
                end else begin
                    tgt = ex_pc_i + ex_imm_i;
                end
                tk  = is_jal_i || is_jalr_i || branch_taken_i;
                nxt = tk ? tgt : ex_pc_i + 64'd4;
                if (tk && (tgt % 4) != 0) begin
                    m_mis = 1; m_maddr = tgt;
                end else begin
                    m_upd = 1; m_upc = ex_pc_i; m_utk = tk; m_utgt = tgt;
                    m_bcnt = m_bcnt + 1;
                    if ((pred_taken_i != tk) || (tk && pred_target_i != tgt)) begin
                        m_busy = 1; m_rv = 1; m_stall = 1; m_flush = 1; m_rpc = nxt;
                        m_mcnt = m_mcnt + 1;
                    end
                end
            end
        end
    end

    // Scoreboard compare on every falling edge
    always @(negedge clk) begin
        chk("redirect_valid", redirect_valid_o, m_rv);
        chk("flush", flush_o, m_flush);
        chk("ex_stall", ex_stall_o, m_stall);
        chk("misalign", misalign_o, m_mis);
        chk("upd_valid", upd_valid_o, m_upd);
        if (m_rv)  chk("redirect_pc", redirect_pc_o, m_rpc);
        if (m_mis) chk("misalign_addr", misalign_addr_o, m_maddr);
        if (m_upd) begin
            chk("upd_pc", upd_pc_o, m_upc);
            chk("upd_taken", upd_taken_o, m_utk);
            chk("upd_target", upd_target_o, m_utgt);
        end
`ifdef BRANCH_PERF_CNT_EN
        chk("branch_cnt", branch_cnt_o, m_bcnt);
        chk("mispredict_cnt", mispredict_cnt_o, m_mcnt);
`endif
    end

    // Driver tasks
    task automatic drive_idle();
        ex_valid_i = 0; is_b_type_i = 0; is_jal_i = 0; is_jalr_i = 0; branch_taken_i = 0;
        ex_pc_i = 0; ex_imm_i = 0; jalr_base_i = 0; pred_taken_i = 0; pred_target_i = 0;
    endtask

    // kind: 0=B-type 1=JAL 2=JALR 3=valid non-ctl 4=B-type flag without valid
    task automatic present(input int kind, input logic [63:0] pc, input logic [63:0] imm,
                           input logic [63:0] base, input logic bt, input logic pt,
                           input logic [63:0] ptgt);
        ex_valid_i     = (kind != 4);
        is_b_type_i    = (kind == 0 || kind == 4);
        is_jal_i       = (kind == 1);
        is_jalr_i      = (kind == 2);
        branch_taken_i = bt;
        ex_pc_i = pc; ex_imm_i = imm; jalr_base_i = base;
        pred_taken_i = pt; pred_target_i = ptgt;
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rv"}, redirect_valid_o, 0);
        chk({tag, "_rpc"}, redirect_pc_o, 0);
        chk({tag, "_flush"}, flush_o, 0);
        chk({tag, "_stall"}, ex_stall_o, 0);
        chk({tag, "_mis"}, misalign_o, 0);
        chk({tag, "_maddr"}, misalign_addr_o, 0);
        chk({tag, "_upd"}, upd_valid_o, 0);
        chk({tag, "_upc"}, upd_pc_o, 0);
        chk({tag, "_utk"}, upd_taken_o, 0);
        chk({tag, "_utgt"}, upd_target_o, 0);
`ifdef BRANCH_PERF_CNT_EN
        chk({tag, "_bcnt"}, branch_cnt_o, 0);
        chk({tag, "_mcnt"}, mispredict_cnt_o, 0);
`endif
    endtask

    initial begin
        resetn = 0;
        redirect_ready_i = 1;
        drive_idle();
        idle_cycle(); idle_cycle();
        chk_all_zero("reset");
        resetn = 1;
        @(negedge clk);

        // BEQ mispredicted not-taken, fetch ready immediately
        present(0, 64'h1000, 64'h40, 0, 1, 0, 0);
        @(negedge clk);
        chk("beq_rv", redirect_valid_o, 1);
        chk("beq_rpc", redirect_pc_o, 64'h1040);
        chk("beq_flush", flush_o, 1);
        chk("beq_stall", ex_stall_o, 1);
        chk("beq_upd", upd_valid_o, 1);
        chk("beq_utk", upd_taken_o, 1);
        chk("beq_utgt", upd_target_o, 64'h1040);
        chk("model_rpc", m_rpc, 64'h1040);
        idle_cycle(); @(negedge clk);
        chk("beq_accepted_rv", redirect_valid_o, 0);
        chk("beq_flush_once", flush_o, 0);

        // Same BEQ with fetch back-pressure for 3 cycles, new ctl during the wait
        redirect_ready_i = 0;
        present(0, 64'h1000, 64'h40, 0, 1, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            present(0, 64'h2000, 64'h10, 0, 0, 1, 0);
            @(negedge clk);
            chk("wait_rpc", redirect_pc_o, 64'h1040);
            chk("wait_stall", ex_stall_o, 1);
            chk("wait_upd", upd_valid_o, 0);
            chk("wait_flush", flush_o, 0);
        end
        redirect_ready_i = 1;
        present(1, 64'h5000, 64'h100, 0, 0, 0, 0);
        @(negedge clk);
        chk("after_accept_rv", redirect_valid_o, 0);
        chk("after_accept_stall", ex_stall_o, 0);
        chk("after_accept_upd", upd_valid_o, 0);

        // BNE predicted taken but falls through
        present(0, 64'h2000, 64'h10, 0, 0, 1, 64'h2010);
        @(negedge clk);
        chk("bne_rpc", redirect_pc_o, 64'h2004);
        chk("bne_utk", upd_taken_o, 0);
        idle_cycle(); @(negedge clk);

        // Correct prediction: update only
        present(0, 64'h2000, 64'h10, 0, 1, 1, 64'h2010);
        @(negedge clk);
        chk("correct_rv", redirect_valid_o, 0);
        chk("correct_upd", upd_valid_o, 1);

        // JAL with negative offset and a wrong predicted target
        present(1, 64'h4000, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, 64'h5000);
        @(negedge clk);
        chk("jal_rpc", redirect_pc_o, 64'h3FF8);
        idle_cycle(); @(negedge clk);

        // Not-taken branch at the top of the address space wraps to 0
        present(0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 0, 0, 1, 64'h4);
        @(negedge clk);
        chk("wrap_rpc", redirect_pc_o, 64'h0);
        idle_cycle(); @(negedge clk);

        // JALR misaligned, then aligned after bit-0 clear
        present(2, 64'h3000, 64'h4, 64'h3003, 0, 0, 0);
        @(negedge clk);
        chk("jalr_mis", misalign_o, 1);
        chk("jalr_maddr", misalign_addr_o, 64'h3006);
        chk("jalr_mis_rv", redirect_valid_o, 0);
        chk("jalr_mis_flush", flush_o, 0);
        present(2, 64'h3000, 64'h4, 64'h3001, 0, 1, 64'h3004);
        @(negedge clk);
        chk("jalr_ok_mis", misalign_o, 0);
        chk("jalr_ok_utgt", upd_target_o, 64'h3004);
        chk("jalr_ok_rv", redirect_valid_o, 0);

        // Misaligned taken branch vs. the same offset not taken
        present(0, 64'h1000, 64'h2, 0, 1, 0, 0);
        @(negedge clk);
        chk("b_mis_addr", misalign_addr_o, 64'h1002);
        present(0, 64'h1000, 64'h2, 0, 0, 0, 0);
        @(negedge clk);
        chk("b_nt_mis", misalign_o, 0);

        // Non-control activity produces nothing
        present(3, 64'h6000, 64'h20, 0, 1, 0, 0);
        @(negedge clk);
        present(4, 64'h6000, 64'h20, 0, 1, 0, 0);
        @(negedge clk);

        // Reset while a redirect is outstanding
        redirect_ready_i = 0;
        present(0, 64'h1000, 64'h40, 0, 1, 0, 0);
        #1 resetn = 0;
        #1 chk_all_zero("async_rst");
        idle_cycle(); idle_cycle();
        resetn = 1;
        redirect_ready_i = 1;
        idle_cycle(); @(negedge clk);
        chk("post_rst_rv", redirect_valid_o, 0);
        chk("post_rst_rpc", redirect_pc_o, 0);
        idle_cycle(); @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
